// File: rtl/bcd_seq.sv
// bcd_seq: sequential binary-to-BCD converter (double dabble, one shift per clock).
//
// Parameters:
//   IN_WIDTH - binary operand width, 2..32
//   DIGITS   - number of BCD output digits, 1..10 (may be fewer than needed;
//              overflow then reports the lost high digits)
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   start    - conversion request, only honoured while idle
//   in       - binary operand, captured on the accept cycle
//   busy     - conversion in progress (cycle after accept through the cycle
//              before done)
//   done     - one-cycle pulse when digits/overflow are refreshed
//   digits   - packed BCD result, digit 0 (ones) in [3:0]; held between results
//   overflow - result did not fit in DIGITS digits
//   sign     - (only with BCD_SEQ_SIGNED_EN) result was negative
//
// Build option: define BCD_SEQ_SIGNED_EN to treat in as two's complement and
// add the sign output; the magnitude is converted.
//
// Outputs are registered, so busy/done/digits reflect the state one cycle
// later: busy stays high through the DONE state cycle and done is seen in
// the first IDLE cycle afterwards (IN_WIDTH+2 cycles from start to done).

module bcd_seq #(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  overflow
`ifdef BCD_SEQ_SIGNED_EN
  ,
  output logic                  sign
`endif
);

  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              state, state_n;
  logic [IN_WIDTH-1:0] bin, bin_n;
  logic [BW-1:0]       bcd_work, bcd_n;
  logic [BW-1:0]       bcd_adj;
  logic                ovf_acc, ovf_acc_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                busy_n, done_n, overflow_n;
  logic [BW-1:0]       digits_n;
  logic [IN_WIDTH-1:0] load_val;

`ifdef BCD_SEQ_SIGNED_EN
  logic sign_pend, sign_pend_n, sign_n;

  // Magnitude of a negative operand; the most negative value maps to
  // 2^(IN_WIDTH-1), which still fits as an unsigned IN_WIDTH-bit number.
  always_comb begin
    load_val = in;
    if (in[IN_WIDTH-1]) begin
      load_val = -in;
    end
  end
`else
  always_comb begin
    load_val = in;
  end
`endif

  // Add-3 correction for every working digit above 4 ahead of the shift.
  always_comb begin
    bcd_adj = bcd_work;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_work[4*i +: 4] > 4'd4) begin
        bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_n    = state;
    bin_n      = bin;
    bcd_n      = bcd_work;
    ovf_acc_n  = ovf_acc;
    cnt_n      = cnt;
    busy_n     = busy;
    done_n     = 1'b0;
    digits_n   = digits;
    overflow_n = overflow;
`ifdef BCD_SEQ_SIGNED_EN
    sign_pend_n = sign_pend;
    sign_n      = sign;
`endif

    unique case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          bin_n     = load_val;
          bcd_n     = '0;
          ovf_acc_n = 1'b0;
          cnt_n     = CW'(IN_WIDTH);
          busy_n    = 1'b1;
          state_n   = S_SHIFT;
`ifdef BCD_SEQ_SIGNED_EN
          sign_pend_n = in[IN_WIDTH-1];
`endif
        end
      end

      S_SHIFT: begin
        // Bits pushed out of the top digit are decimal weight beyond DIGITS.
        bcd_n     = {bcd_adj[BW-2:0], bin[IN_WIDTH-1]};
        bin_n     = {bin[IN_WIDTH-2:0], 1'b0};
        ovf_acc_n = ovf_acc | bcd_adj[BW-1];
        cnt_n     = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = S_DONE;
        end
      end

      S_DONE: begin
        digits_n   = bcd_work;
        overflow_n = ovf_acc;
        done_n     = 1'b1;
        busy_n     = 1'b0;
        state_n    = S_IDLE;
`ifdef BCD_SEQ_SIGNED_EN
        sign_n = sign_pend;
`endif
      end

      default: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bin      <= '0;
      bcd_work <= '0;
      ovf_acc  <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      digits   <= '0;
      overflow <= 1'b0;
`ifdef BCD_SEQ_SIGNED_EN
      sign_pend <= 1'b0;
      sign      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      bin      <= bin_n;
      bcd_work <= bcd_n;
      ovf_acc  <= ovf_acc_n;
      cnt      <= cnt_n;
      busy     <= busy_n;
      done     <= done_n;
      digits   <= digits_n;
      overflow <= overflow_n;
`ifdef BCD_SEQ_SIGNED_EN
      sign_pend <= sign_pend_n;
      sign      <= sign_n;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_seq.sv
// tb_bcd_seq: scoreboard bench for bcd_seq.
// dut0 uses the default parameters; dut4 uses DIGITS=4 to reach overflow.
// Expected results come from a decimal reference (repeated divide by ten),
// pushed on accept and popped when done pulses.

`timescale 1ns/1ps

module tb_bcd_seq;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start0, start4;
  logic [W-1:0]  in0, in4;
  logic          busy0, done0, ovf0;
  logic          busy4, done4, ovf4;
  logic [19:0]   dig0;
  logic [15:0]   dig4;
`ifdef BCD_SEQ_SIGNED_EN
  logic          sign0, sign4;
`endif

  bcd_seq #(.IN_WIDTH(W), .DIGITS(5)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .start    (start0),
    .in       (in0),
    .busy     (busy0),
    .done     (done0),
    .digits   (dig0),
    .overflow (ovf0)
`ifdef BCD_SEQ_SIGNED_EN
    ,
    .sign     (sign0)
`endif
  );

  bcd_seq #(.IN_WIDTH(W), .DIGITS(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .start    (start4),
    .in       (in4),
    .busy     (busy4),
    .done     (done4),
    .digits   (dig4),
    .overflow (ovf4)
`ifdef BCD_SEQ_SIGNED_EN
    ,
    .sign     (sign4)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input longint unsigned got,
                       input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    longint unsigned dig;
    bit              ovf;
    bit              sgn;
  } exp_t;

  function automatic exp_t model(input logic [W-1:0] v, input int nd);
    exp_t            e;
    longint unsigned m;
    e.sgn = 1'b0;
    m     = 64'(v);
`ifdef BCD_SEQ_SIGNED_EN
    if (v[W-1]) begin
      e.sgn = 1'b1;
      m     = (64'd1 << W) - 64'(v);
    end
`endif
    e.dig = 0;
    for (int i = 0; i < nd; i++) begin
      e.dig = e.dig | ((m % 10) << (4 * i));
      m     = m / 10;
    end
    e.ovf = (m != 0);
    return e;
  endfunction

  exp_t        q0[$];
  exp_t        q4[$];
  int unsigned ndone0 = 0, ndone4 = 0;
  int unsigned nexp0 = 0, nexp4 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      ndone0++;
      if (q0.size() == 0) begin
        check("dut0 unexpected done", 1, 0);
      end else begin
        e = q0.pop_front();
        check("dut0 digits", 64'(dig0), e.dig);
        check("dut0 overflow", 64'(ovf0), 64'(e.ovf));
`ifdef BCD_SEQ_SIGNED_EN
        check("dut0 sign", 64'(sign0), 64'(e.sgn));
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      ndone4++;
      if (q4.size() == 0) begin
        check("dut4 unexpected done", 1, 0);
      end else begin
        e = q4.pop_front();
        check("dut4 digits", 64'(dig4), e.dig);
        check("dut4 overflow", 64'(ovf4), 64'(e.ovf));
`ifdef BCD_SEQ_SIGNED_EN
        check("dut4 sign", 64'(sign4), 64'(e.sgn));
`endif
      end
    end
  end

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy0 : busy4;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? done0 : done4;
  endfunction

  function automatic longint unsigned dig_of(input int sel);
    return (sel == 0) ? 64'(dig0) : 64'(dig4);
  endfunction

  task automatic drive(input int sel, input logic s, input logic [W-1:0] v);
    if (sel == 0) begin
      start0 = s; in0 = v;
    end else begin
      start4 = s; in4 = v;
    end
  endtask

  // One conversion. poke_at: cycle (counted from the accept edge) on which a
  // second start is pulsed while busy. abort_at: cycle on which rst is raised.
  // Zero disables either. Returns on the negedge where done is visible.
  task automatic convert(input int sel, input logic [W-1:0] v,
                         input int poke_at, input int abort_at);
    int              t;
    int              c;
    longint unsigned held;
    exp_t            e;
    t = 0;
    while (busy_of(sel) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("idle timeout", 1, 0);
    held = dig_of(sel);
    e    = model(v, (sel == 0) ? 5 : 4);
    if (sel == 0) begin q0.push_back(e); nexp0++; end
    else          begin q4.push_back(e); nexp4++; end
    drive(sel, 1'b1, v);
    @(negedge clk);
    drive(sel, 1'b0, W'($urandom));
    c = 1;
    while (c <= 40) begin
      if (c == 1) check("accepted busy", 64'(busy_of(sel)), 1);
      if (c == poke_at) drive(sel, 1'b1, W'(7));
      if (poke_at != 0 && c == poke_at + 1) drive(sel, 1'b0, W'($urandom));
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 64'(busy_of(sel)), 0);
        check("abort done", 64'(done_of(sel)), 0);
        check("abort digits", dig_of(sel), 0);
        if (sel == 0) begin void'(q0.pop_back()); nexp0--; end
        else          begin void'(q4.pop_back()); nexp4--; end
        t = (sel == 0) ? int'(ndone0) : int'(ndone4);
        repeat (25) @(negedge clk);
        check("abort no done", (sel == 0) ? 64'(ndone0) : 64'(ndone4), 64'(t));
        return;
      end
      if (done_of(sel)) break;
      if (c == 9) check("digits held", dig_of(sel), held);
      if (!busy_of(sel)) begin
        check("busy dropped early", 1, 0);
        break;
      end
      @(negedge clk);
      c++;
    end
    check("latency", 64'(c), W + 2);
    check("busy at done", 64'(busy_of(sel)), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start0 = 1'b0; start4 = 1'b0;
    in0 = '0; in4 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy0", 64'(busy0), 0);
    check("reset done0", 64'(done0), 0);
    check("reset digits0", 64'(dig0), 0);
    check("reset ovf0", 64'(ovf0), 0);
    check("reset busy4", 64'(busy4), 0);
    check("reset digits4", 64'(dig4), 0);
`ifdef BCD_SEQ_SIGNED_EN
    check("reset sign0", 64'(sign0), 0);
`endif

    convert(0, W'(0), 0, 0);
    convert(0, W'(65535), 0, 0);
    convert(0, W'(1234), 0, 0);
    convert(0, W'(999), 5, 0);
    convert(0, W'(4321), 0, 8);
    convert(0, W'(42), 0, 0);
`ifdef BCD_SEQ_SIGNED_EN
    convert(0, 16'hFFFF, 0, 0);
    convert(0, 16'h8000, 0, 0);
    convert(0, 16'h7FFF, 0, 0);
`endif
    for (int i = 0; i < 4; i++) convert(0, W'($urandom), 0, 0);

    convert(1, W'(12345), 0, 0);
    convert(1, W'(9999), 0, 0);
    convert(1, W'(10000), 0, 0);
    convert(1, W'(0), 0, 0);
    for (int i = 0; i < 3; i++) convert(1, W'($urandom), 0, 0);

    repeat (5) @(negedge clk);
    check("dut0 done count", 64'(ndone0), 64'(nexp0));
    check("dut4 done count", 64'(ndone4), 64'(nexp4));
    check("dut0 queue drained", 64'(q0.size()), 0);
    check("dut4 queue drained", 64'(q4.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
